data_memory: RTL and testbench
==============================

# data_memory

Parametrised little-endian RISC-V data memory serving the LOAD/STORE path of the datapath through a valid/ready request port and a registered response port. It adds configurable depth and range checking with error reporting. Accesses that cross a 4-byte word boundary are split into two internal beats by a small state machine. It replaces the fixed 64-byte, always-on-clock-edge data memory in the load/store stage.

## Interface
- `DEPTH_BYTES`, 1024: storage size in bytes; power of two, ≥ 8.
- `ADDR_W`, 32: request address width.
- `ALLOW_MISALIGNED`, 1: 1 = serve misaligned accesses; 0 = flag them as errors.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3:
  - loads: LB 000, LH 001, LW 010, LBU 100, LHU 101;
  - stores: SB 000, SH 001, SW 010.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.

## Operation
- **Handshake:** a request is accepted on a rising edge where `req_valid && req_ready`. Inputs are not sampled otherwise.
- **Storage:** `DEPTH_BYTES/4` words with 4 byte lanes; byte k of a word is address 4·w+k.
- **Access size:** 1, 2 or 4 bytes, from `funct3[1:0]`.
- **Misaligned:** the address is not a multiple of the access size.
- **Crossing:** `addr[1:0] + size > 4`.
- **Error cases** (checked in this priority order; on any error no byte is written, and the response is `rsp_err=1`, `rsp_rdata=0`):
  1. illegal funct3 (load 011/110/111; store ≥ 011);
  2. `addr + size − 1 ≥ DEPTH_BYTES`, computed at ADDR_W+1 bits so it cannot wrap;
  3. misaligned while `ALLOW_MISALIGNED=0`.
- **Store:** write only the addressed byte lanes, then return a response with `rsp_rdata=0` and `rsp_err=0`.
- **Load:** assemble the bytes little-endian.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- **FSM states:**
  - IDLE: `req_ready=1`. An accepted non-crossing or error request is served in one beat and stays in IDLE. An accepted crossing request performs beat 1 (lower word) and goes to SECOND.
  - SECOND: `req_ready=0`. Performs beat 2 on word w+1 and returns to IDLE.
  - Beat-1 read bytes are held in a register and merged with the beat-2 bytes.
- **Ordering:** requests are strictly serialised, so a load always observes every earlier accepted store.

## Timing
- **Reset:** while `rst` is high at an edge, outputs after that edge are `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, and the state is IDLE. `req_ready` rises to 1 on the first edge with `rst` low. Memory contents are not cleared.
- **Single-beat latency:** request accepted at edge N → `rsp_valid=1` for the cycle after edge N+1, with data valid in that cycle.
- **Crossing latency:** accepted at edge N → `req_ready=0` for the cycle after edge N; response one cycle later than a single-beat request.
- **Throughput:**
  - non-crossing requests: one per cycle, back-to-back;
  - crossing requests: one per two cycles.
- **Reset during SECOND:** beat 2 is abandoned and no response is issued. For a crossing store, the beat-1 bytes remain written and the beat-2 bytes are unwritten.
- **`rsp_rdata`/`rsp_err` between pulses:** hold their last value; only `rsp_valid` marks a response.

## Structure
- **Package `data_memory_pkg`:**
  - funct3 constants (LB…LHU, SB/SH/SW);
  - FSM state enum {IDLE, SECOND};
  - size-from-funct3 function;
  - load-extension function.
- **Sub-module `byte_lane_ram`:** `DEPTH_BYTES/4` × 32 storage with 4 byte-enables and synchronous read. The top level holds the FSM, the range/alignment checks, lane steering and the merge register.

## Test plan
1. SW 0x008 ← 0xDEADBEEF, then loads:
   - LW 0x008 → 0xDEADBEEF;
   - LB 0x00B → 0xFFFFFFDE;
   - LBU 0x00B → 0x000000DE;
   - LH 0x00A → 0xFFFFDEAD;
   - LHU 0x008 → 0x0000BEEF.
2. Crossing accesses with `ALLOW_MISALIGNED=1`:
   - SW 0x006 ← 0x11223344 → `req_ready` low for 1 cycle;
   - LW 0x006 → 0x11223344, with the response 2 cycles after acceptance;
   - LBU 0x006 → 0x44;
   - LBU 0x009 → 0x11;
   - LH 0x001 is non-crossing → 1-cycle response, no stall.
3. Range checks with `DEPTH_BYTES=1024`:
   - LW 0x3FE → `rsp_err=1`, `rsp_rdata=0`;
   - SB 0x3FF ← 0xA5 → ok; LBU 0x3FF → 0xA5;
   - SH 0x3FF → `rsp_err=1`, 0x3FF unchanged.
4. Illegal funct3:
   - load funct3 011 → err;
   - store funct3 100 to 0x010 (preloaded 0x12345678) → err; LW 0x010 → 0x12345678.
5. `ALLOW_MISALIGNED=0`: LH 0x001 → err; LW 0x004 → normal single-cycle response.
6. Reset during SECOND of SW 0x006 ← 0xAABBCCDD (preloaded 0):
   - no `rsp_valid` is issued;
   - after reset, LBU 0x006 → 0xDD and LBU 0x008 → 0x00.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressed RISC-V data memory: funct3 encodings,
// FSM states and the size/extension helpers used by the load/store path.
package data_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    function automatic logic [2:0] access_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_SW);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_LB:   return {{24{d[7]}}, d[7:0]};
            F3_LH:   return {{16{d[15]}}, d[15:0]};
            F3_LBU:  return {24'd0, d[7:0]};
            F3_LHU:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_byte_lane_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
module byte_lane_ram #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WA          = $clog2(DEPTH_BYTES / 4)
) (
    input  logic          clk,
    input  logic [WA-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_BYTES / 4];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k])
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_memory.sv
// Load/store data memory with range/alignment checking; word-crossing accesses are
// split into two beats and the beat-1 read bytes are merged with beat 2.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_BYTES      = 1024,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WA = $clog2(DEPTH_BYTES / 4);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_live;

    logic            w_accept;
    logic            w_beat2;
    logic [2:0]      w_size;
    logic [2:0]      w_size_m1;
    logic [ADDR_W:0] w_last;
    logic            w_illegal;
    logic            w_range;
    logic            w_mis;
    logic            w_err;
    logic            w_cross;
    logic [3:0]      w_mask4;
    logic [7:0]      w_be;
    logic [63:0]     w_wlane;
    logic [WA-1:0]   w_word;

    logic [WA-1:0]   w_ram_addr;
    logic [3:0]      w_ram_we;
    logic [31:0]     w_ram_wdata;
    logic [31:0]     w_ram_rdata;

    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [WA-1:0]   r_word;
    logic            r_err;
    logic            r_cross;
    logic [3:0]      r_be_hi;
    logic [31:0]     r_wdata_hi;

    logic            r_vld_p1;
    logic            r_first_p1;
    logic [31:0]     r_lo_p2;

    logic [55:0]     w_span;
    logic [31:0]     w_merged;
    logic [31:0]     w_load;

    assign req_ready = r_live && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready && !rst;
    assign w_beat2   = (r_state == SECOND) && !rst;

    // Request decode: size, the three error classes in priority order, crossing detection
    assign w_size    = access_size(req_funct3[1:0]);
    assign w_size_m1 = w_size - 3'd1;
    assign w_illegal = funct3_illegal(req_we, req_funct3);
    assign w_last    = {1'b0, req_addr} + (ADDR_W+1)'(w_size) - (ADDR_W+1)'(1);
    assign w_range   = (w_last >= (ADDR_W+1)'(DEPTH_BYTES));
    assign w_mis     = |(req_addr[1:0] & w_size_m1[1:0]);
    assign w_err     = w_illegal || w_range || (w_mis && !ALLOW_MISALIGNED);
    assign w_cross   = !w_err && (({1'b0, req_addr[1:0]} + w_size) > 3'd4);
    assign w_word    = req_addr[WA+1:2];

    // Lanes 0-3 belong to the addressed word, lanes 4-7 to the next word
    assign w_mask4 = (w_size == 3'd1) ? 4'b0001 : (w_size == 3'd2) ? 4'b0011 : 4'b1111;
    assign w_be    = {4'b0000, w_mask4} << req_addr[1:0];
    assign w_wlane = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};

    always_comb begin
        w_ram_addr  = w_word;
        w_ram_we    = 4'b0000;
        w_ram_wdata = w_wlane[31:0];
        if (w_beat2) begin
            w_ram_addr  = r_word + WA'(1);
            w_ram_wdata = r_wdata_hi;
            if (r_we)
                w_ram_we = r_be_hi;
        end else if (w_accept && req_we && !w_err) begin
            w_ram_we = w_be[3:0];
        end
    end

    byte_lane_ram #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .WA         (WA)
    ) u_ram (
        .clk    (clk),
        .i_addr (w_ram_addr),
        .i_we   (w_ram_we),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_cross) w_state_nxt = SECOND;
            SECOND:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: a beat has been issued to the RAM; request context is held for the merge
    always_ff @(posedge clk) begin
        r_live <= !rst;
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
        end else begin
            r_vld_p1   <= (w_accept && !w_cross) || w_beat2;
            r_first_p1 <= w_accept && w_cross;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_off      <= req_addr[1:0];
            r_word     <= w_word;
            r_err      <= w_err;
            r_cross    <= w_cross;
            r_be_hi    <= w_be[7:4];
            r_wdata_hi <= w_wlane[63:32];
        end
    end

    // Stage p1 -> p2: beat-1 bytes parked until beat 2 returns
    always_ff @(posedge clk) begin
        if (r_first_p1)
            r_lo_p2 <= w_ram_rdata;
    end

    // A crossing access never needs the top byte of the second word
    assign w_span = r_cross ? {w_ram_rdata[23:0], r_lo_p2} : {24'd0, w_ram_rdata};

    always_comb begin
        case (r_off)
            2'd0:    w_merged = w_span[31:0];
            2'd1:    w_merged = w_span[39:8];
            2'd2:    w_merged = w_span[47:16];
            default: w_merged = w_span[55:24];
        endcase
    end

    assign w_load = load_extend(r_funct3, w_merged);

    // Response register: data/err hold between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= r_vld_p1;
            if (r_vld_p1) begin
                rsp_err   <= r_err;
                rsp_rdata <= (r_err || r_we) ? 32'd0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a byte-array reference model.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_na;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, req_ready_na;
    logic        rsp_valid, rsp_valid_na;
    logic [31:0] rsp_rdata, rsp_rdata_na;
    logic        rsp_err, rsp_err_na;

    int n_cmp  = 0;
    int n_fail = 0;

    byte unsigned mem    [1024];
    byte unsigned mem_na [1024];

    always #5 clk = ~clk;

    data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(req_ready_na),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_na), .rsp_rdata(rsp_rdata_na), .rsp_err(rsp_err_na)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: bytes in a flat array, response derived from the access rules
    task automatic model(input bit na, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit e_err, output bit e_cross, output logic [31:0] e_data);
        int     sz;
        bit     illegal, out_of_range, mis;
        longint last;
        logic [31:0] v;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
        last = longint'(addr) + sz - 1;
        out_of_range = (last >= 1024);
        mis = (addr % sz) != 0;
        e_err = illegal || out_of_range || (mis && na);
        e_cross = !e_err && ((addr % 4) + sz > 4);
        e_data = 32'd0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) begin
                    if (na) mem_na[addr + i] = wdata[8*i +: 8];
                    else    mem[addr + i]    = wdata[8*i +: 8];
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++)
                    v = v | (32'(na ? mem_na[addr + i] : mem[addr + i]) << (8 * i));
                case (f3)
                    3'b000:  e_data = v[7]  ? (v | 32'hFFFF_FF00) : v;
                    3'b001:  e_data = v[15] ? (v | 32'hFFFF_0000) : v;
                    default: e_data = v;
                endcase
            end
        end
    endtask

    task automatic xact(input bit na, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] od, output logic oe);
        bit          e_err, e_cross, got;
        logic [31:0] e_data;
        int          lat;
        model(na, we, f3, addr, wdata, e_err, e_cross, e_data);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (na) req_valid_na = 1'b1; else req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (na ? req_ready_na : req_ready) break;
            @(negedge clk);
        end
        chk({tag, ".ready"}, 32'(na ? req_ready_na : req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_valid_na = 1'b0;
        chk({tag, ".stall"}, 32'(na ? req_ready_na : req_ready), e_cross ? 32'd0 : 32'd1);
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (na ? rsp_valid_na : rsp_valid) begin
                got = 1'b1; lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), e_cross ? 32'd2 : 32'd1);
        od = na ? rsp_rdata_na : rsp_rdata;
        oe = na ? rsp_err_na : rsp_err;
        chk({tag, ".err"}, 32'(oe), 32'(e_err));
        chk({tag, ".data"}, od, e_data);
    endtask

    initial begin
        logic [31:0] d, da, db, wd;
        logic        e;
        bit          ee, ec, we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        rst = 1'b1; req_valid = 1'b0; req_valid_na = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",    32'(req_ready), 32'd0);
        chk("rst.valid",    32'(rsp_valid), 32'd0);
        chk("rst.rdata",    rsp_rdata,      32'd0);
        chk("rst.err",      32'(rsp_err),   32'd0);
        chk("rst.ready_na", 32'(req_ready_na), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.ready_up", 32'(req_ready), 32'd1);

        for (int w = 0; w < 256; w++)
            xact(1'b0, 1'b1, 3'b010, 32'(4 * w), $urandom, "pre", d, e);

        // Basic word store and sub-word loads
        xact(1'b0, 1'b1, 3'b010, 32'h008, 32'hDEADBEEF, "t1.sw", d, e);
        xact(1'b0, 1'b0, 3'b010, 32'h008, 0, "t1.lw",  d, e); chk("t1.lw.k",  d, 32'hDEADBEEF);
        xact(1'b0, 1'b0, 3'b000, 32'h00B, 0, "t1.lb",  d, e); chk("t1.lb.k",  d, 32'hFFFFFFDE);
        xact(1'b0, 1'b0, 3'b100, 32'h00B, 0, "t1.lbu", d, e); chk("t1.lbu.k", d, 32'h000000DE);
        xact(1'b0, 1'b0, 3'b001, 32'h00A, 0, "t1.lh",  d, e); chk("t1.lh.k",  d, 32'hFFFFDEAD);
        xact(1'b0, 1'b0, 3'b101, 32'h008, 0, "t1.lhu", d, e); chk("t1.lhu.k", d, 32'h0000BEEF);

        // Word-crossing accesses
        xact(1'b0, 1'b1, 3'b010, 32'h006, 32'h11223344, "t2.sw", d, e);
        xact(1'b0, 1'b0, 3'b010, 32'h006, 0, "t2.lw",  d, e); chk("t2.lw.k",  d, 32'h11223344);
        xact(1'b0, 1'b0, 3'b100, 32'h006, 0, "t2.lbu", d, e); chk("t2.lbu.k", d, 32'h00000044);
        xact(1'b0, 1'b0, 3'b100, 32'h009, 0, "t2.lbu9", d, e); chk("t2.lbu9.k", d, 32'h00000011);
        xact(1'b0, 1'b0, 3'b001, 32'h001, 0, "t2.lh1", d, e);

        // Range limits
        xact(1'b0, 1'b0, 3'b010, 32'h3FE, 0, "t3.lw", d, e);
        chk("t3.lw.err", 32'(e), 32'd1); chk("t3.lw.k", d, 32'd0);
        xact(1'b0, 1'b1, 3'b000, 32'h3FF, 32'h000000A5, "t3.sb", d, e);
        chk("t3.sb.err", 32'(e), 32'd0);
        xact(1'b0, 1'b1, 3'b001, 32'h3FF, 32'h00005A5A, "t3.sh", d, e);
        chk("t3.sh.err", 32'(e), 32'd1);
        xact(1'b0, 1'b0, 3'b100, 32'h3FF, 0, "t3.lbu", d, e); chk("t3.lbu.k", d, 32'h000000A5);

        // Illegal funct3
        xact(1'b0, 1'b1, 3'b010, 32'h010, 32'h12345678, "t4.pre", d, e);
        xact(1'b0, 1'b0, 3'b011, 32'h010, 0, "t4.ld011", d, e); chk("t4.ld011.err", 32'(e), 32'd1);
        xact(1'b0, 1'b1, 3'b100, 32'h010, 32'hFFFFFFFF, "t4.st100", d, e);
        chk("t4.st100.err", 32'(e), 32'd1);
        xact(1'b0, 1'b0, 3'b010, 32'h010, 0, "t4.lw", d, e); chk("t4.lw.k", d, 32'h12345678);

        // Misaligned accesses rejected on the strict instance
        xact(1'b1, 1'b1, 3'b010, 32'h004, 32'hCAFEF00D, "t5.sw", d, e);
        xact(1'b1, 1'b0, 3'b001, 32'h001, 0, "t5.lh", d, e); chk("t5.lh.err", 32'(e), 32'd1);
        xact(1'b1, 1'b0, 3'b010, 32'h004, 0, "t5.lw", d, e); chk("t5.lw.k", d, 32'hCAFEF00D);

        // Back-to-back single-beat loads: one response per cycle
        model(1'b0, 1'b0, 3'b010, 32'h008, 0, ee, ec, da);
        model(1'b0, 1'b0, 3'b010, 32'h010, 0, ee, ec, db);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h008; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h010;
        chk("b2b.ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b.v1", 32'(rsp_valid), 32'd1);
        chk("b2b.d1", rsp_rdata, da);
        @(posedge clk);
        #1;
        chk("b2b.v2", 32'(rsp_valid), 32'd1);
        chk("b2b.d2", rsp_rdata, db);
        @(posedge clk);
        #1;
        chk("b2b.v3", 32'(rsp_valid), 32'd0);

        // Reset landing in the second beat of a crossing store
        xact(1'b0, 1'b1, 3'b010, 32'h004, 32'd0, "t6.pre4", d, e);
        xact(1'b0, 1'b1, 3'b010, 32'h008, 32'd0, "t6.pre8", d, e);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h006; req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        chk("t6.stall", 32'(req_ready), 32'd0);
        mem[6] = 8'hDD; mem[7] = 8'hCC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6.rst.ready", 32'(req_ready), 32'd0);
        chk("t6.rst.valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t6.novalid", 32'(rsp_valid), 32'd0);
        end
        xact(1'b0, 1'b0, 3'b100, 32'h006, 0, "t6.lbu6", d, e); chk("t6.lbu6.k", d, 32'h000000DD);
        xact(1'b0, 1'b0, 3'b100, 32'h008, 0, "t6.lbu8", d, e); chk("t6.lbu8.k", d, 32'h00000000);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (we)
                f3 = 3'($urandom_range(0, 2));
            else begin
                sel = $urandom_range(0, 4);
                f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'($urandom_range(1016, 1040));
            else if (sel < 5)  a = 32'($urandom_range(0, 31));
            else               a = 32'($urandom_range(0, 1023));
            wd = $urandom;
            xact(1'b0, we, f3, a, wd, "rnd", d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
